// File: rtl/vec_pipe_reg_skid_if.sv
// Handshake bundle for vec_pipe_reg_skid: upstream in_* beat and downstream out_* beat.
// The pipeline register is the slave; whatever feeds and drains it uses master.
interface vec_pipe_reg_skid_if #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*LANE_W-1:0]   in_data;
  logic [LANES-1:0]          in_lane_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   out_data;
  logic [LANES-1:0]          out_lane_en;

  modport master (
    output in_valid, in_data, in_lane_en, out_ready,
    input  in_ready, out_valid, out_data, out_lane_en
  );

  modport slave (
    input  in_valid, in_data, in_lane_en, out_ready,
    output in_ready, out_valid, out_data, out_lane_en
  );
endinterface

// File: rtl/vec_pipe_reg_skid.sv
// Multi-lane pipeline register with a 2-entry skid buffer, lane masking and flush.
// Define VEC_PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module vec_pipe_reg_skid #(
  parameter int LANE_W = 8,
  parameter int LANES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  vec_pipe_reg_skid_if.slave bus
`ifdef VEC_PIPE_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);
  localparam int W = LANES * LANE_W;

  // Encoding is {skid_v, main_v}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_reg;
  logic [W-1:0]     main_data_reg;
  logic [W-1:0]     skid_data_reg;
  logic [LANES-1:0] main_en_reg;
  logic [LANES-1:0] skid_en_reg;
  logic             in_ready_reg;
  logic [W-1:0]     in_masked;
  logic             main_v;
  logic             acc;
  logic             pop;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi = gi + 1) begin : g_lane_mask
      assign in_masked[gi*LANE_W +: LANE_W] =
        bus.in_lane_en[gi] ? bus.in_data[gi*LANE_W +: LANE_W] : {LANE_W{1'b0}};
    end
  endgenerate

  assign main_v = (state_reg != EMPTY);
  assign acc    = bus.in_valid & in_ready_reg;
  assign pop    = main_v & bus.out_ready;

  // in_ready is recomputed from the next state so it never depends on out_ready combinationally
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b0;
      main_data_reg <= '0;
      main_en_reg   <= '0;
      skid_data_reg <= '0;
      skid_en_reg   <= '0;
    end else if (flush) begin
      state_reg     <= EMPTY;
      in_ready_reg  <= 1'b1;
      main_data_reg <= '0;
      main_en_reg   <= '0;
      skid_data_reg <= '0;
      skid_en_reg   <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          in_ready_reg <= 1'b1;
          if (acc) begin
            state_reg     <= ONE;
            main_data_reg <= in_masked;
            main_en_reg   <= bus.in_lane_en;
          end
        end
        ONE: begin
          in_ready_reg <= 1'b1;
          if (acc && pop) begin
            main_data_reg <= in_masked;
            main_en_reg   <= bus.in_lane_en;
          end else if (acc) begin
            state_reg     <= FULL;
            in_ready_reg  <= 1'b0;
            skid_data_reg <= in_masked;
            skid_en_reg   <= bus.in_lane_en;
          end else if (pop) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          in_ready_reg <= pop;
          if (pop) begin
            state_reg     <= ONE;
            main_data_reg <= skid_data_reg;
            main_en_reg   <= skid_en_reg;
          end
        end
        default: begin
          state_reg    <= EMPTY;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = main_v;
  assign bus.out_data    = main_data_reg;
  assign bus.out_lane_en = main_en_reg;

`ifdef VEC_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(negedge clk) begin
    if (!reset || flush) begin
      stall_cnt_reg <= '0;
    end else if (main_v && !bus.out_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif
endmodule

// File: tb/tb_vec_pipe_reg_skid.sv
// Scoreboard bench for vec_pipe_reg_skid: directed scenarios then random traffic,
// checked against a queue-based model of the buffer contents.
module tb_vec_pipe_reg_skid;
  localparam int LANE_W = 8;
  localparam int LANES  = 4;
  localparam int W      = LANE_W * LANES;

  typedef struct {
    logic [W-1:0]     data;
    logic [LANES-1:0] en;
  } beat_t;

  logic clk;
  logic reset;
  logic flush;
`ifdef VEC_PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  vec_pipe_reg_skid_if #(.LANE_W(LANE_W), .LANES(LANES)) bus ();

  vec_pipe_reg_skid #(.LANE_W(LANE_W), .LANES(LANES)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef VEC_PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  bit    model_ok = 0;
  bit    exp_ready = 0;
  bit    cleared = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mask_vec(input logic [W-1:0] d, input logic [LANES-1:0] en);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      if (en[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
    return r;
  endfunction

  // Drive one beat; state updates at the following falling edge.
  task automatic cycle(input bit rst_n, input bit fl, input bit v,
                       input logic [W-1:0] d, input logic [LANES-1:0] en, input bit ordy);
    beat_t b;
    @(posedge clk);
    #1;
    reset          = rst_n;
    flush          = fl;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_lane_en = en;
    bus.out_ready  = ordy;
    if (!rst_n || fl) begin
      exp_q.delete();
    end else if (v && exp_ready && model_ok) begin
      b.data = mask_vec(d, en);
      b.en   = en;
      exp_q.push_back(b);
      cleared = 0;
      $display("push data=%08h en=%b depth=%0d", b.data, b.en, exp_q.size());
    end
  endtask

  // Monitor: checks outputs at the rising edge, then retires handshakes for the coming falling edge.
  initial begin
    bit ov_s;
    beat_t b;
    forever begin
      @(posedge clk);
      ov_s = bus.out_valid;
      if (model_ok) begin
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_q.size() != 0});
        chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
        if (exp_q.size() != 0) begin
          chk("out_data", {32'd0, bus.out_data}, {32'd0, exp_q[0].data});
          chk("out_lane_en", {60'd0, bus.out_lane_en}, {60'd0, exp_q[0].en});
        end else if (cleared) begin
          chk("out_data_clr", {32'd0, bus.out_data}, 64'd0);
          chk("out_lane_en_clr", {60'd0, bus.out_lane_en}, 64'd0);
        end
`ifdef VEC_PIPE_STALL_CNT_EN
        chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_cnt});
`endif
      end
      #2;
      if (!reset) begin
        model_ok  = 1;
        exp_ready = 0;
        cleared   = 1;
        exp_cnt   = 16'd0;
      end else if (model_ok) begin
        if (flush) begin
          cleared = 1;
          exp_cnt = 16'd0;
        end else begin
          if (ov_s && !bus.out_ready && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
          if (ov_s && bus.out_ready && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            $display("pop  data=%08h en=%b depth=%0d", b.data, b.en, exp_q.size());
          end
        end
        exp_ready = (exp_q.size() < 2);
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_lane_en = '0;
    bus.out_ready  = 1'b0;

    // Reset held for two edges, then released
    cycle(0, 0, 0, 32'h0, 4'h0, 0);
    cycle(0, 0, 1, 32'hDEADBEEF, 4'hF, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Streaming
    cycle(1, 0, 1, 32'h04030201, 4'hF, 1);
    cycle(1, 0, 1, 32'h08070605, 4'hF, 1);
    cycle(1, 0, 1, 32'h0C0B0A09, 4'hF, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Skid fill then drain
    cycle(1, 0, 1, 32'h11111111, 4'hF, 0);
    cycle(1, 0, 1, 32'h22222222, 4'hF, 0);
    cycle(1, 0, 1, 32'h99999999, 4'hF, 0);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Lane mask, including an all-disabled beat
    cycle(1, 0, 1, 32'hAABBCCDD, 4'b0101, 0);
    cycle(1, 0, 1, 32'h12345678, 4'b0000, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Flush while FULL, with a beat offered on the same edge
    cycle(1, 0, 1, 32'h44444444, 4'hF, 0);
    cycle(1, 0, 1, 32'h55555555, 4'hF, 0);
    cycle(1, 1, 1, 32'h33333333, 4'hF, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 1, 32'h66666666, 4'hF, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Reset mid-transfer
    cycle(1, 0, 1, 32'h77777777, 4'hF, 0);
    cycle(1, 0, 1, 32'h88888888, 4'hF, 0);
    cycle(0, 0, 1, 32'hBADBAD00, 4'hF, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Stall for five edges, then flush
    cycle(1, 0, 1, 32'hCAFEF00D, 4'hF, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h0, 4'h0, 0);
    cycle(1, 1, 0, 32'h0, 4'h0, 0);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 39) == 0),
            $urandom_range(0, 1), $urandom, 4'($urandom), ($urandom_range(0, 2) != 0));
    end
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);

`ifdef VEC_PIPE_STALL_CNT_EN
    // Long stall to reach counter saturation
    cycle(1, 0, 1, 32'h0BADCAFE, 4'hF, 0);
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
    end
    cycle(1, 0, 0, 32'h0, 4'h0, 0);
    chk("stall_sat", {48'd0, stall_cnt}, 64'hFFFF);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
    cycle(1, 0, 0, 32'h0, 4'h0, 1);
`endif

    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
